// File: rtl/am_audio_dc_pwm_pkg.sv
// Shared widths, saturation limits and the 24-bit to 16-bit audio saturator
// used by the AM audio DC-removal / PWM path.
package am_audio_pkg;

  localparam int AUDIO_W   = 16;
  localparam int GAIN_W    = 3;
  localparam int GAIN_MAX  = 7;
  localparam int AGC_QUIET = 2 ** 13;

  localparam logic signed [AUDIO_W-1:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [AUDIO_W-1:0] SAT_NEG = 16'sh8000;

  typedef logic signed [AUDIO_W-1:0] audio_t;
  typedef logic        [GAIN_W-1:0]  gain_t;

  typedef struct packed {
    audio_t audio;
    logic   clip;
  } sat_t;

  function automatic sat_t saturate(input logic signed [23:0] g);
    sat_t r;
    if (g > 24'sh007FFF) begin
      r.audio = SAT_POS;
      r.clip  = 1'b1;
    end else if (g < 24'shFF8000) begin
      r.audio = SAT_NEG;
      r.clip  = 1'b1;
    end else begin
      r.audio = audio_t'(g[AUDIO_W-1:0]);
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/am_audio_pwm.sv
// Free-running PWM carrier for the audio pin; duty is latched only at the end
// of each period so a new sample never cuts a pulse short.
module am_audio_pwm #(
  parameter int unsigned PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] audio_msb,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_duty  <= {1'b1, {(PWM_BITS-1){1'b0}}};
      pwm_out <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      // Flipping the sign bit turns two's complement into offset binary.
      if (&r_cnt)
        r_duty <= {~audio_msb[PWM_BITS-1], audio_msb[PWM_BITS-2:0]};
      pwm_out <= (r_cnt < r_duty);
    end
  end

endmodule

// File: rtl/am_audio_dc_pwm.sv
// AM audio back end: leaky-average DC removal, 2^gain shift with saturation,
// PWM output. Define AM_AUDIO_AGC_EN to build the automatic gain control.
module am_audio_dc_pwm
  import am_audio_pkg::*;
#(
  parameter int unsigned DC_SHIFT   = 4,
  parameter int unsigned GAIN_SHIFT = 0,
  parameter int unsigned PWM_BITS   = 10,
  parameter int unsigned AGC_HOLD   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       d_valid,
  input  logic [15:0]                d_in,
  output logic signed [AUDIO_W-1:0]  audio_out,
  output logic                       audio_valid,
  output logic                       clip,
  output logic [GAIN_W-1:0]          gain,
  output logic                       pwm_out
);

  localparam int unsigned ACC_W = 16 + DC_SHIFT;

  if (GAIN_SHIFT > GAIN_MAX || AGC_HOLD == 0 || PWM_BITS < 2 || PWM_BITS > 16) begin : g_param_check
    $error("am_audio_dc_pwm: parameter out of range");
  end

  logic [ACC_W-1:0]   r_dc_acc;
  logic [15:0]        w_dc_est;
  logic signed [16:0] r_ac;
  logic               r_ac_valid;
  logic signed [23:0] w_g;
  sat_t               w_sat;
  gain_t              w_gain;

  assign w_dc_est = r_dc_acc[ACC_W-1:DC_SHIFT];

  // Stage 1: subtract the pre-update estimate, then leak it toward the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dc_acc   <= '0;
      r_ac       <= '0;
      r_ac_valid <= 1'b0;
    end else begin
      r_ac_valid <= d_valid;
      if (d_valid) begin
        r_ac     <= $signed({1'b0, d_in}) - $signed({1'b0, w_dc_est});
        r_dc_acc <= r_dc_acc + ACC_W'(d_in) - ACC_W'(w_dc_est);
      end
    end
  end

  assign w_g   = {{7{r_ac[16]}}, r_ac} <<< w_gain;
  assign w_sat = saturate(w_g);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out   <= '0;
      audio_valid <= 1'b0;
      clip        <= 1'b0;
    end else begin
      audio_valid <= r_ac_valid;
      clip        <= r_ac_valid & w_sat.clip;
      if (r_ac_valid)
        audio_out <= w_sat.audio;
    end
  end

`ifdef AM_AUDIO_AGC_EN
  localparam int unsigned QW    = $clog2(AGC_HOLD + 1);
  localparam audio_t      Q_LIM = audio_t'(AGC_QUIET);

  logic [QW-1:0] r_quiet;
  gain_t         r_gain;
  logic          w_quiet;

  assign w_quiet = (w_sat.audio < Q_LIM) && (w_sat.audio > -Q_LIM);

  // Gain moves on the same edge that publishes the sample that caused it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gain  <= gain_t'(GAIN_SHIFT);
      r_quiet <= '0;
    end else if (r_ac_valid) begin
      if (w_sat.clip) begin
        if (r_gain != '0)
          r_gain <= r_gain - gain_t'(1);
        r_quiet <= '0;
      end else if (w_quiet) begin
        if (r_quiet == QW'(AGC_HOLD - 1)) begin
          if (r_gain != gain_t'(GAIN_MAX))
            r_gain <= r_gain + gain_t'(1);
          r_quiet <= '0;
        end else begin
          r_quiet <= r_quiet + QW'(1);
        end
      end else begin
        r_quiet <= '0;
      end
    end
  end

  assign w_gain = r_gain;
`else
  assign w_gain = gain_t'(GAIN_SHIFT);
`endif

  assign gain = w_gain;

  am_audio_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .reset     (reset),
    .audio_msb (audio_out[AUDIO_W-1 -: PWM_BITS]),
    .pwm_out   (pwm_out)
  );

endmodule
